// File: rtl/nibbler_button_port.sv
// Pushbutton input port for the Nibbler CPU.
// Each button is synchronised and debounced. A rising debounced level is
// captured as a sticky press flag. A CPU read returns either the live levels
// or the press flags. In latch mode, a read clears the flags it returned.
// irq is the OR of the masked press flags.
//
// Handshake: a read is accepted on a rising clk edge when rdEn & phase.
// dataOut then updates one cycle later and holds that value until the next
// accepted read. The port never stalls, so it has no ready signal.
module nibbler_button_port #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LATCH_MODE      = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] buttonsRaw,
  input  logic                phase,
  input  logic                rdEn,
  input  logic [CHANNELS-1:0] irqMask,
  output logic [CHANNELS-1:0] dataOut,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] pressFlags,
  output logic                irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_out;
  logic [CW-1:0]       cnt_q [CHANNELS];
  logic [CW-1:0]       cnt_d [CHANNELS];
  logic [CHANNELS-1:0] level_d;
  logic [CHANNELS-1:0] new_press;
  logic [CHANNELS-1:0] flags_d;
  logic [CHANNELS-1:0] data_d;
  logic                irq_d;
  logic                rd_acc;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rd_acc   = rdEn & phase;

  // Synchroniser shift chain. Stage 0 samples the raw asynchronous inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= buttonsRaw;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Debounce counters. Any cycle where the input agrees with level restarts
  // the count. The count never goes past CNT_MAX, so it cannot overflow.
  always_comb begin
    level_d = level;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = '0;
      if (sync_out[i] != level[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = sync_out[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Press flags, read data and irq for the next cycle. When a new press and
  // a clearing read occur in the same cycle, the new press keeps its flag.
  always_comb begin
    new_press = level_d & ~level;
    flags_d   = pressFlags | new_press;
    data_d    = dataOut;
    if (rd_acc) begin
      data_d = (LATCH_MODE != 0) ? pressFlags : level;
      if (LATCH_MODE != 0) flags_d = (pressFlags & ~pressFlags) | new_press;
    end
    irq_d = |(flags_d & irqMask);
  end

  // State registers for the counters, levels, flags, read data and irq.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
      level      <= '0;
      pressFlags <= '0;
      dataOut    <= '0;
      irq        <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
      level      <= level_d;
      pressFlags <= flags_d;
      dataOut    <= data_d;
      irq        <= irq_d;
    end
  end

endmodule
